// File: rtl/operand_collector.sv
// Operand collector: gathers up to NumOperands register reads from one bank port per instruction.
// Define OPERAND_COLLECTOR_DEDUP_EN to read a register once when several operands name it.
module operand_collector #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned NumRegisters = 32,
    parameter int unsigned NumOperands  = 3,
    parameter int unsigned TagWidth     = 4,
    localparam int unsigned RegAddrWidth = $clog2(NumRegisters)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [TagWidth-1:0]              in_tag_i,
    input  logic [NumOperands-1:0]           in_used_i,
    input  logic [NumOperands*RegAddrWidth-1:0] in_addr_i,
    output logic                             bank_read_valid_o,
    input  logic                             bank_read_ready_i,
    output logic [RegAddrWidth-1:0]          bank_read_addr_o,
    input  logic                             bank_rsp_valid_i,
    input  logic [RegAddrWidth-1:0]          bank_rsp_addr_i,
    input  logic [DataWidth-1:0]             bank_rsp_data_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [TagWidth-1:0]              out_tag_o,
    output logic [NumOperands*DataWidth-1:0] out_data_o
);

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e                            state;
    logic [TagWidth-1:0]               tag;
    logic [NumOperands-1:0]            used;
    logic [NumOperands-1:0]            pending;
    logic [NumOperands-1:0]            received;
    logic [NumOperands-1:0]            inflight;
    logic [NumOperands*RegAddrWidth-1:0] addrs;
    logic [NumOperands*DataWidth-1:0]  data;
    logic [RegAddrWidth-1:0]           issued_addr;
    logic                              armed;

    logic [RegAddrWidth-1:0]           rd_addr;
    logic [NumOperands-1:0]            issue_mask;
    logic [NumOperands-1:0]            received_next;
    logic                              found;
    logic                              bank_fire;
    logic                              rsp_hit;

    // Lowest-index pending operand selects the address; the mask says which slots it fills.
    always_comb begin
        rd_addr    = '0;
        issue_mask = '0;
        found      = 1'b0;
        for (int i = 0; i < NumOperands; i++) begin
            if (pending[i] && !found) begin
                found         = 1'b1;
                rd_addr       = addrs[i*RegAddrWidth +: RegAddrWidth];
                issue_mask[i] = 1'b1;
            end
        end
`ifdef OPERAND_COLLECTOR_DEDUP_EN
        for (int i = 0; i < NumOperands; i++) begin
            if (pending[i] && (addrs[i*RegAddrWidth +: RegAddrWidth] == rd_addr)) begin
                issue_mask[i] = 1'b1;
            end
        end
`endif
    end

    assign bank_read_valid_o = (state == StCollect) && (|pending);
    assign bank_read_addr_o  = rd_addr;
    assign bank_fire         = bank_read_valid_o && bank_read_ready_i;
    assign rsp_hit           = bank_rsp_valid_i && (|inflight);
    assign received_next     = received | (rsp_hit ? inflight : '0);
    assign out_tag_o         = tag;
    assign out_data_o        = data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= StIdle;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            tag         <= '0;
            used        <= '0;
            pending     <= '0;
            received    <= '0;
            inflight    <= '0;
            addrs       <= '0;
            data        <= '0;
            issued_addr <= '0;
            armed       <= 1'b0;
        end else begin
            armed    <= 1'b1;
            inflight <= '0;
            if (rsp_hit) begin
                received <= received_next;
                for (int i = 0; i < NumOperands; i++) begin
                    if (inflight[i]) data[i*DataWidth +: DataWidth] <= bank_rsp_data_i;
                end
            end
            unique case (state)
                StIdle: begin
                    if (in_valid_i) begin
                        tag        <= in_tag_i;
                        used       <= in_used_i;
                        addrs      <= in_addr_i;
                        pending    <= in_used_i;
                        received   <= '0;
                        data       <= '0;
                        in_ready_o <= 1'b0;
                        if (in_used_i == '0) begin
                            state       <= StDone;
                            out_valid_o <= 1'b1;
                        end else begin
                            state <= StCollect;
                        end
                    end
                end
                StCollect: begin
                    if (bank_fire) begin
                        pending     <= pending & ~issue_mask;
                        inflight    <= issue_mask;
                        issued_addr <= rd_addr;
                    end
                    if (received_next == used) begin
                        state       <= StDone;
                        out_valid_o <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state       <= StIdle;
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifndef SYNTHESIS
    // The first cycle after reset may carry a response to a read issued before reset.
    always @(posedge clk_i) begin
        if (rst_ni && armed && bank_rsp_valid_i) begin
            assert (inflight != '0);
            if (inflight != '0) assert (bank_rsp_addr_i == issued_addr);
        end
    end
`endif

endmodule

// File: doc/operand_collector.md
Name: operand_collector

Overview:
- Initiator for a single register file bank read port.
- Accepts one instruction carrying up to NumOperands register addresses and issues one bank read per used operand.
- Captures the one-cycle-latency read responses and presents the complete operand set, with its tag, to the execution stage over a valid/ready handshake.
- Sits between the dispatcher and the functional units of the compute unit.

Parameters:
- DataWidth, 32, width of one register.
- NumRegisters, 32, registers per bank; RegAddrWidth = $clog2(NumRegisters) (dependent, not overridable).
- NumOperands, 3, maximum source operands per instruction (>= 1).
- TagWidth, 4, width of the opaque instruction tag.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  instruction valid.
- in_ready_o  out  1  collector can accept an instruction.
- in_tag_i  in  TagWidth  instruction tag.
- in_used_i  in  NumOperands  bit i set = operand i required.
- in_addr_i  in  NumOperands*RegAddrWidth  operand i register address at slice i.
- bank_read_valid_o  out  1  read request to bank.
- bank_read_ready_i  in  1  bank accepts read.
- bank_read_addr_o  out  RegAddrWidth  read address.
- bank_rsp_valid_i  in  1  bank read data valid (one cycle after an accepted read).
- bank_rsp_addr_i  in  RegAddrWidth  address echoed by bank.
- bank_rsp_data_i  in  DataWidth  read data.
- out_valid_o  out  1  operand set complete.
- out_ready_i  in  1  consumer accepts.
- out_tag_o  out  TagWidth  tag of the collected instruction.
- out_data_o  out  NumOperands*DataWidth  operand i data at slice i.

Behaviour:
- FSM states: IDLE, COLLECT, DONE. Reset state is IDLE; all registers cleared.
- Reset values: in_ready_o=1, bank_read_valid_o=0, bank_read_addr_o=0, out_valid_o=0, out_tag_o=0, out_data_o=0.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o, capture tag, addresses and used mask; pending=used, received=0, inflight=0, all data slots cleared to 0.
  - If used==0, go to DONE; otherwise go to COLLECT.
- COLLECT:
  - in_ready_o=0.
  - bank_read_valid_o=|pending; bank_read_addr_o = address of the lowest-index pending operand.
  - On bank handshake: clear that pending bit; inflight <= issue mask (one-hot of the index). Otherwise inflight <= 0.
  - bank_read_valid_o, once asserted, holds with a stable address until accepted.
- Response:
  - When bank_rsp_valid_i && inflight!=0: write bank_rsp_data_i into every slot in inflight and set those received bits.
  - A response with inflight==0 is ignored.
  - Simulation assertions: bank_rsp_addr_i equals the issued address; a response never arrives without an inflight read.
- Completion:
  - When received==used after the update, go to DONE next cycle.
  - A response and a new issue in the same cycle are both handled.
- DONE:
  - out_valid_o=1; out_tag_o and out_data_o are stable. Unused slots are 0.
  - On out_ready_i, go to IDLE.
  - in_ready_o=0 in DONE; no overlap with a new instruction.
- Latency, with the bank always ready and N used operands:
  - Input handshake in cycle 0.
  - Issues in cycles 1..N; last response in cycle N+1.
  - out_valid_o rises in cycle N+2.
  - N=0: out_valid_o rises in cycle 1.
- Bank stall: bank_read_ready_i low holds the request. No timeout.
- Reset mid-operation: returns to IDLE immediately (asynchronous). Any in-flight response after reset is ignored because inflight=0.

Optional Feature:
- Macro: OPERAND_COLLECTOR_DEDUP_EN.
- Defined: the issue mask includes all pending operands whose address equals the lowest pending operand's address. These are cleared from pending together, and one response fills all of them. Duplicate registers are read once.
- Undefined: the issue mask is one-hot and every used operand is read separately, even when addresses repeat.

Test Plan:
- Tag 5, used=3'b111, addr 1/2/3, bank always ready, bank returns data 32'h100+addr -> reads issued to 1,2,3 in cycles 1-3; out_valid_o in cycle 5; out_data_o = {103,102,101}, out_tag_o=5.
- Used=3'b000, tag 9 -> no bank request; out_valid_o in cycle 1 with out_data_o=0 and out_tag_o=9.
- Used=3'b101, addr0=7, addr2=4; bank_read_ready_i low for 3 cycles -> bank_read_addr_o held at 7 with valid high while stalled; slot 1 stays 0; completes after stall.
- out_ready_i held low 4 cycles in DONE -> outputs stable and in_ready_o=0 throughout; IDLE the cycle after out_ready_i rises.
- Addr 6/6/6, used=3'b111 -> with DEDUP_EN: exactly 1 bank read, out_valid_o in cycle 3; without DEDUP_EN: 3 reads, out_valid_o in cycle 5; all slots equal.
- rst_ni pulsed low mid-COLLECT after 1 issue -> all outputs reset values; the stray bank_rsp_valid_i next cycle is ignored; the next instruction completes normally.
